// File: rtl/qspinor_rd_seq.sv
// qspinor_rd_seq: turns a host word-read into an opcode/address/dummy/data command sequence for qspinor_io
module qspinor_rd_seq #(
    parameter logic [7:0]  OPCODE   = 8'h6B,
    parameter logic [1:0]  DATA_WID = 2'd2,
    parameter logic [3:0]  DMY_CNT  = 4'd7,
    parameter int unsigned CS_GAP   = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic [23:0] addr,
    input  logic [1:0]  len,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        cs_n,
    output logic        io_cmd_trig,
    output logic [7:0]  io_cmd_body,
    input  logic        io_cmd_done,
    output logic        io_do_rdy,
    input  logic        io_do_req,
    output logic [7:0]  io_do,
    output logic        io_di_rdy,
    input  logic        io_di_req,
    input  logic [7:0]  io_di
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CSSU = 3'd1;
    localparam logic [2:0] S_OPC  = 3'd2;
    localparam logic [2:0] S_ADDR = 3'd3;
    localparam logic [2:0] S_DMY  = 3'd4;
    localparam logic [2:0] S_DATA = 3'd5;
    localparam logic [2:0] S_CSH  = 3'd6;
    localparam logic [2:0] S_GAP  = 3'd7;
    localparam logic [2:0] GAP_MAX = 3'(CS_GAP);

    logic [2:0]  state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [1:0]  len_q, len_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        wait_q, wait_d;
    logic        sent_q, sent_d;
    logic        cs_n_q, cs_n_d;
    logic [2:0]  gap_q, gap_d;
    logic [31:0] rdata_q, rdata_d;
    logic        cmd_st;

    // Command phases issue a trigger whenever no engine command is outstanding
    assign cmd_st      = (state_q >= S_OPC) && (state_q <= S_DATA);
    assign io_cmd_trig = cmd_st && !wait_q;
    assign io_cmd_body = (state_q == S_DMY)  ? {2'b10, 2'b00, DMY_CNT} :
                         (state_q == S_DATA) ? {2'b00, DATA_WID, 4'h0} : 8'h40;
    assign io_do       = (state_q == S_OPC) ? OPCODE :
                         (cnt_q == 2'd0)    ? addr_q[23:16] :
                         (cnt_q == 2'd1)    ? addr_q[15:8]  : addr_q[7:0];
    assign io_do_rdy   = ((state_q == S_OPC) || (state_q == S_ADDR)) && !sent_q;
    assign io_di_rdy   = (state_q == S_DATA);
    assign busy        = (state_q != S_IDLE) && (state_q <= S_DATA);
    assign done        = (state_q == S_CSH);
    assign rdata       = rdata_q;
    assign cs_n        = cs_n_q;

    // Phase sequencing, byte streaming and chip-select spacing
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        rdata_d = rdata_q;
        wait_d  = io_cmd_trig ? 1'b1 : io_cmd_done ? 1'b0 : wait_q;
        sent_d  = io_cmd_done ? 1'b0 : (io_do_req && io_do_rdy) ? 1'b1 : sent_q;
        if (io_di_req && state_q == S_DATA)
            rdata_d[{cnt_q, 3'b000} +: 8] = io_di;
        case (state_q)
            S_IDLE: if (req && gap_q == GAP_MAX) begin
                addr_d  = addr;
                len_d   = len;
                cnt_d   = 2'd0;
                rdata_d = '0;
                state_d = S_CSSU;
            end
            S_CSSU: state_d = S_OPC;
            S_OPC: if (io_cmd_done) begin
                cnt_d   = 2'd0;
                state_d = S_ADDR;
            end
            S_ADDR: if (io_cmd_done) begin
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == 2'd2) ? S_DMY : S_ADDR;
            end
            S_DMY: if (io_cmd_done) begin
                cnt_d   = 2'd0;
                state_d = S_DATA;
            end
            S_DATA: if (io_cmd_done) begin
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == len_q) ? S_CSH : S_DATA;
            end
            S_CSH: begin
                gap_d   = 3'd1;
                state_d = (GAP_MAX == 3'd1) ? S_IDLE : S_GAP;
            end
            default: begin
                gap_d   = gap_q + 3'd1;
                state_d = (gap_q + 3'd1 == GAP_MAX) ? S_IDLE : S_GAP;
            end
        endcase
        cs_n_d = (state_d == S_IDLE) || (state_d == S_GAP);
    end

    // State registers; reset abandons any transaction and releases chip select
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= 1'b0;
            sent_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            gap_q   <= GAP_MAX;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            sent_q  <= sent_d;
            cs_n_q  <= cs_n_d;
            gap_q   <= gap_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_qspinor_rd_seq.sv
// tb_qspinor_rd_seq: directed checks of the read sequencer against a simple engine model
module tb_qspinor_rd_seq;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req = 1'b0;
    logic [23:0] addr = '0;
    logic [1:0]  len = '0;
    logic        busy, done, cs_n, io_cmd_trig, io_do_rdy, io_di_rdy;
    logic [31:0] rdata;
    logic [7:0]  io_cmd_body, io_do;
    logic        io_cmd_done = 1'b0;
    logic        io_do_req = 1'b0;
    logic        io_di_req = 1'b0;
    logic [7:0]  io_di = '0;

    int nvec = 0;
    int nerr = 0;
    int ntrig = 0;
    int hi_run = 0;
    int stab_err = 0;
    int do_dly = 0;
    logic [7:0] din[$];
    logic [7:0] dos[$];
    logic [7:0] bodies[$];
    int gaps[$];

    always #5 clk = ~clk;

    qspinor_rd_seq dut (
        .clk(clk), .rstn(rstn), .req(req), .addr(addr), .len(len),
        .busy(busy), .done(done), .rdata(rdata), .cs_n(cs_n),
        .io_cmd_trig(io_cmd_trig), .io_cmd_body(io_cmd_body), .io_cmd_done(io_cmd_done),
        .io_do_rdy(io_do_rdy), .io_do_req(io_do_req), .io_do(io_do),
        .io_di_rdy(io_di_rdy), .io_di_req(io_di_req), .io_di(io_di)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Trigger count and chip-select high-run lengths
    initial forever begin
        @(posedge clk); #1;
        if (io_cmd_trig) ntrig++;
        if (cs_n) hi_run++;
        else begin
            if (hi_run > 0) gaps.push_back(hi_run);
            hi_run = 0;
        end
    end

    // Engine model: one command at a time, optional stall before consuming an output byte
    initial begin
        logic [7:0] b, v;
        @(posedge clk); #1;
        forever begin
            if (io_cmd_trig) begin
                b = io_cmd_body;
                v = io_do;
                bodies.push_back(b);
                repeat (2 + (b[6] ? do_dly : 0)) begin
                    @(posedge clk); #1;
                    if (b[6] && (!io_do_rdy || io_do !== v)) stab_err++;
                    if (io_cmd_trig) stab_err++;
                end
                if (b[6]) begin
                    dos.push_back(io_do);
                    io_do_req = 1'b1;
                end else if (!b[7]) begin
                    if (din.size() > 0) io_di = din.pop_front();
                    else io_di = 8'hEE;
                    io_di_req = 1'b1;
                end
                @(posedge clk); #1;
                io_do_req = 1'b0;
                io_di_req = 1'b0;
                io_cmd_done = 1'b1;
                @(posedge clk); #1;
                io_cmd_done = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    task automatic do_read(input logic [23:0] a, input logic [1:0] l, output logic [31:0] rd, output int ok);
        @(posedge clk); #1;
        req = 1'b1; addr = a; len = l;
        @(posedge clk); #1;
        req = 1'b0;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            if (done) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        rd = rdata;
    endtask

    function automatic int n_data();
        int n = 0;
        foreach (bodies[i]) if (bodies[i] == 8'h20) n++;
        return n;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [7:0] exp_b[9];
        logic [7:0] exp_do[4];
        int ok, t0, k, sd;
        exp_b = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h87, 8'h20, 8'h20, 8'h20, 8'h20};
        exp_do = '{8'h6B, 8'h12, 8'h34, 8'h56};
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        check("rst_cs_n", 32'(cs_n), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rdata", rdata, 0);
        repeat (20) @(posedge clk);
        #1;
        check("idle_trigs", ntrig, 0);
        check("idle_cs_n", 32'(cs_n), 1);

        din = '{8'h11, 8'h22, 8'h33, 8'h44};
        dos.delete(); bodies.delete(); t0 = ntrig;
        do_read(24'h123456, 2'd3, rd, ok);
        check("rd4_done", ok, 1);
        check("rd4_rdata", rd, 32'h44332211);
        check("rd4_busy_at_done", 32'(busy), 0);
        check("rd4_cs_hold", 32'(cs_n), 0);
        check("rd4_trigs", ntrig - t0, 9);
        check("rd4_ndo", dos.size(), 4);
        check("rd4_nbody", bodies.size(), 9);
        for (int i = 0; i < 4; i++) check($sformatf("rd4_do%0d", i), 32'(dos.size() > i ? dos[i] : 8'hXX), 32'(exp_do[i]));
        for (int i = 0; i < 9; i++) check($sformatf("rd4_body%0d", i), 32'(bodies.size() > i ? bodies[i] : 8'hXX), 32'(exp_b[i]));
        @(posedge clk); #1;
        check("rd4_cs_release", 32'(cs_n), 1);
        check("rd4_done_pulse", 32'(done), 0);

        repeat (10) @(posedge clk);
        din = '{8'hAA};
        bodies.delete(); t0 = ntrig;
        do_read(24'h000010, 2'd0, rd, ok);
        check("rd1_done", ok, 1);
        check("rd1_rdata", rd, 32'h000000AA);
        check("rd1_ndata", n_data(), 1);
        check("rd1_trigs", ntrig - t0, 6);

        repeat (10) @(posedge clk);
        #1;
        gaps.delete();
        din = '{8'h01, 8'h02, 8'h03};
        req = 1'b1; addr = 24'h00ABCD; len = 2'd0;
        k = 0;
        for (int i = 0; i < 2000 && k < 3; i++) begin
            @(posedge clk); #1;
            if (done) k++;
        end
        req = 1'b0;
        check("held_ndone", k, 3);
        check("held_rdata", rdata, 32'h00000003);
        repeat (10) @(posedge clk);
        #1;
        check("held_nruns", gaps.size(), 3);
        check("held_gap1", gaps.size() > 1 ? gaps[1] : -1, 3);
        check("held_gap2", gaps.size() > 2 ? gaps[2] : -1, 3);

        repeat (10) @(posedge clk);
        #1;
        din = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        bodies.delete();
        req = 1'b1; addr = 24'hABCDEF; len = 2'd3;
        @(posedge clk); #1;
        req = 1'b0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (n_data() >= 2) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("abort_reached_data", ok, 1);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("abort_cs_n", 32'(cs_n), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        rstn = 1'b1;
        sd = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) sd++;
        end
        check("abort_no_done", sd, 0);
        din.delete();
        din = '{8'h5A, 8'hA5};
        do_read(24'h000100, 2'd1, rd, ok);
        check("post_abort_done", ok, 1);
        check("post_abort_rdata", rd, 32'h0000A55A);

        repeat (10) @(posedge clk);
        do_dly = 5; stab_err = 0;
        din = '{8'h77};
        dos.delete(); t0 = ntrig;
        do_read(24'hABCDEF, 2'd0, rd, ok);
        do_dly = 0;
        check("slow_done", ok, 1);
        check("slow_rdata", rd, 32'h00000077);
        check("slow_stable", stab_err, 0);
        check("slow_trigs", ntrig - t0, 6);
        check("slow_do", dos.size() == 4 ? {dos[0], dos[1], dos[2], dos[3]} : 32'hXXXXXXXX, 32'h6BABCDEF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
